// File: rtl/ula_bcd_display_if.sv
// ula_bcd_display_if: link between the ULA result and the display stage.
// The master side (ULA/testbench) drives ON and value. The slave side (the
// display stage) returns the seven-segment digits, the BCD result, the sign
// and the busy flag.
interface ula_bcd_display_if;
    logic        ON;
    logic [7:0]  value;
    logic [6:0]  HEX0;
    logic [6:0]  HEX1;
    logic [6:0]  HEX2;
    logic [6:0]  HEX3;
    logic [11:0] bcd;
    logic        neg;
    logic        busy;

    modport master (
        output ON, value,
        input  HEX0, HEX1, HEX2, HEX3, bcd, neg, busy
    );

    modport slave (
        input  ON, value,
        output HEX0, HEX1, HEX2, HEX3, bcd, neg, busy
    );
endinterface

// File: rtl/ula_bcd_display.sv
// ula_bcd_display: converts the ULA's signed 8-bit result to sign + 3 BCD
// digits and drives four seven-segment displays.
// The binary-to-BCD conversion is sequential (shift-and-add-3, one bit per
// clock). It runs only when the sampled inputs change, or once after reset.
// Optional feature macro: BCD_LEADING_ZERO_BLANK_EN (blanks leading zero
// hundreds/tens digits). When it is undefined, every magnitude digit is shown.
module ula_bcd_display #(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    ula_bcd_display_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] HEX_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    state_t      state_q, state_d;
    logic [7:0]  snap_value_q, snap_value_d;
    logic        snap_on_q, snap_on_d;
    logic [19:0] sr_q, sr_d;        // {hundreds, tens, units, binary}
    logic [2:0]  cnt_q, cnt_d;
    logic        force_q, force_d;
    logic        busy_q, busy_d;
    logic [11:0] bcd_q, bcd_d;
    logic        neg_q, neg_d;
    logic [6:0]  hex0_q, hex0_d;
    logic [6:0]  hex1_q, hex1_d;
    logic [6:0]  hex2_q, hex2_d;
    logic [6:0]  hex3_q, hex3_d;

    // Active-high segment pattern, bits {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    seg_digit = 7'h3F;
            4'd1:    seg_digit = 7'h06;
            4'd2:    seg_digit = 7'h5B;
            4'd3:    seg_digit = 7'h4F;
            4'd4:    seg_digit = 7'h66;
            4'd5:    seg_digit = 7'h6D;
            4'd6:    seg_digit = 7'h7D;
            4'd7:    seg_digit = 7'h07;
            4'd8:    seg_digit = 7'h7F;
            4'd9:    seg_digit = 7'h6F;
            default: seg_digit = SEG_BLANK;
        endcase
    endfunction

    // Apply the board polarity to an active-high pattern.
    function automatic logic [6:0] to_pins(input logic [6:0] p);
        to_pins = SEG_ACTIVE_LOW ? ~p : p;
    endfunction

    // The add-3 correction that precedes each shift.
    function automatic logic [3:0] add3(input logic [3:0] n);
        add3 = (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // The intermediate values below are declared at module level. Always_comb
    // must not declare a variable and give it a value in the same statement.
    logic [19:0] adj;
    logic [3:0]  dig_h, dig_t, dig_u;
    logic [6:0]  pat2, pat1;

    // Next-state, datapath and output-pattern logic.
    always_comb begin
        // NOTE: assign every variable its default first so that no path
        // through the case leaves it unassigned. An unassigned path infers a latch.
        state_d      = state_q;
        snap_value_d = snap_value_q;
        snap_on_d    = snap_on_q;
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        force_d      = force_q;
        bcd_d        = bcd_q;
        neg_d        = neg_q;
        hex0_d       = hex0_q;
        hex1_d       = hex1_q;
        hex2_d       = hex2_q;
        hex3_d       = hex3_q;

        adj   = {add3(sr_q[19:16]), add3(sr_q[15:12]), add3(sr_q[11:8]), sr_q[7:0]};
        dig_h = sr_q[19:16];
        dig_t = sr_q[15:12];
        dig_u = sr_q[11:8];
`ifdef BCD_LEADING_ZERO_BLANK_EN
        pat2  = (dig_h == 4'd0) ? SEG_BLANK : seg_digit(dig_h);
        pat1  = (dig_h == 4'd0 && dig_t == 4'd0) ? SEG_BLANK : seg_digit(dig_t);
`else
        pat2  = seg_digit(dig_h);
        pat1  = seg_digit(dig_t);
`endif

        case (state_q)
            IDLE: begin
                if (bus.value != snap_value_q || bus.ON != snap_on_q || force_q) begin
                    snap_value_d = bus.value;
                    snap_on_d    = bus.ON;
                    // A negative input is negated here. 8'h80 gives 128 unsigned, so it does not overflow.
                    sr_d         = {12'h000, bus.value[7] ? (~bus.value + 8'd1) : bus.value};
                    cnt_d        = 3'd0;
                    force_d      = 1'b0;
                    state_d      = CONV;
                end
            end
            CONV: begin
                sr_d  = {adj[18:0], 1'b0};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                bcd_d   = sr_q[19:8];
                neg_d   = snap_value_q[7];
                hex3_d  = snap_on_q ? to_pins(snap_value_q[7] ? SEG_MINUS : SEG_BLANK) : HEX_OFF;
                hex2_d  = snap_on_q ? to_pins(pat2) : HEX_OFF;
                hex1_d  = snap_on_q ? to_pins(pat1) : HEX_OFF;
                hex0_d  = snap_on_q ? to_pins(seg_digit(dig_u)) : HEX_OFF;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers. Reset is asynchronous, and it aborts any conversion in progress.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            snap_value_q <= 8'h00;
            snap_on_q    <= 1'b0;
            sr_q         <= 20'h00000;
            cnt_q        <= 3'd0;
            force_q      <= 1'b1;
            busy_q       <= 1'b0;
            bcd_q        <= 12'h000;
            neg_q        <= 1'b0;
            hex0_q       <= HEX_OFF;
            hex1_q       <= HEX_OFF;
            hex2_q       <= HEX_OFF;
            hex3_q       <= HEX_OFF;
        end else begin
            // NOTE: non-blocking assignments make every register sample its
            // pre-edge value. The result then does not depend on statement order.
            state_q      <= state_d;
            snap_value_q <= snap_value_d;
            snap_on_q    <= snap_on_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            force_q      <= force_d;
            busy_q       <= busy_d;
            bcd_q        <= bcd_d;
            neg_q        <= neg_d;
            hex0_q       <= hex0_d;
            hex1_q       <= hex1_d;
            hex2_q       <= hex2_d;
            hex3_q       <= hex3_d;
        end
    end

    assign bus.HEX0 = hex0_q;
    assign bus.HEX1 = hex1_q;
    assign bus.HEX2 = hex2_q;
    assign bus.HEX3 = hex3_q;
    assign bus.bcd  = bcd_q;
    assign bus.neg  = neg_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_ula_bcd_display.sv
// tb_ula_bcd_display: directed test of ula_bcd_display. The DUT uses active-low segments.
// The expected HEX1/HEX2 values depend on whether BCD_LEADING_ZERO_BLANK_EN is defined.
module tb_ula_bcd_display;
    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   busy_cycles;

    ula_bcd_display_if bus ();

    ula_bcd_display #(.SEG_ACTIVE_LOW(1'b1)) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );

`ifdef BCD_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif
    // A leading-zero digit is blank when the macro is defined and shows 0 otherwise.
    localparam logic [6:0] LZ0 = LZ ? 7'h7F : 7'h40;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then sample 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_hex(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bcd(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        rst       = 1'b1;
        bus.ON    = 1'b1;
        bus.value = 8'd0;
        step(2);
        check_hex("rst_hex0", bus.HEX0, 7'h7F);
        check_hex("rst_hex3", bus.HEX3, 7'h7F);
        check_bit("rst_busy", bus.busy, 1'b0);
        check_bcd("rst_bcd", bus.bcd, 12'h000);
        check_bit("rst_neg", bus.neg, 1'b0);

        // First conversion after release (forced). busy must stay high for exactly 9 edges.
        rst = 1'b0;
        busy_cycles = 0;
        repeat (9) begin
            step(1);
            if (bus.busy === 1'b1) busy_cycles++;
        end
        check_hex("zero_not_early", bus.HEX0, 7'h7F);
        step(1);
        check_int("zero_busy_cycles", busy_cycles, 9);
        check_bit("zero_busy_done", bus.busy, 1'b0);
        check_hex("zero_hex0", bus.HEX0, 7'h40);
        check_hex("zero_hex1", bus.HEX1, LZ0);
        check_hex("zero_hex2", bus.HEX2, LZ0);
        check_hex("zero_hex3", bus.HEX3, 7'h7F);
        check_bcd("zero_bcd", bus.bcd, 12'h000);

        // 99
        bus.value = 8'd99;
        step(9);
        check_hex("99_hold_old", bus.HEX0, 7'h40);
        step(1);
        check_hex("99_hex0", bus.HEX0, 7'h10);
        check_hex("99_hex1", bus.HEX1, 7'h10);
        check_hex("99_hex2", bus.HEX2, LZ0);
        check_hex("99_hex3", bus.HEX3, 7'h7F);
        check_bcd("99_bcd", bus.bcd, 12'h099);
        check_bit("99_neg", bus.neg, 1'b0);

        // -128 (8'h80)
        bus.value = 8'h80;
        step(10);
        check_hex("m128_hex3", bus.HEX3, 7'h3F);
        check_hex("m128_hex2", bus.HEX2, 7'h79);
        check_hex("m128_hex1", bus.HEX1, 7'h24);
        check_hex("m128_hex0", bus.HEX0, 7'h00);
        check_bcd("m128_bcd", bus.bcd, 12'h128);
        check_bit("m128_neg", bus.neg, 1'b1);

        // 12, then 8'hC8 (-56) arrives before edge 4. The change is ignored until IDLE.
        bus.value = 8'd12;
        step(3);
        bus.value = 8'hC8;
        step(7);
        check_hex("12_hex1", bus.HEX1, 7'h79);
        check_hex("12_hex0", bus.HEX0, 7'h24);
        check_hex("12_hex3", bus.HEX3, 7'h7F);
        check_bcd("12_bcd", bus.bcd, 12'h012);
        step(9);
        check_bcd("m56_not_early", bus.bcd, 12'h012);
        step(1);
        check_hex("m56_hex3", bus.HEX3, 7'h3F);
        check_hex("m56_hex2", bus.HEX2, LZ0);
        check_hex("m56_hex1", bus.HEX1, 7'h12);
        check_hex("m56_hex0", bus.HEX0, 7'h02);
        check_bcd("m56_bcd", bus.bcd, 12'h056);
        check_bit("m56_neg", bus.neg, 1'b1);

        // 5 with ON=1, then ON=0 (all blank, bcd still updated)
        bus.value = 8'd5;
        step(10);
        check_hex("5_hex0", bus.HEX0, 7'h12);
        check_hex("5_hex1", bus.HEX1, LZ0);
        check_hex("5_hex2", bus.HEX2, LZ0);
        bus.ON = 1'b0;
        step(10);
        check_hex("off_hex0", bus.HEX0, 7'h7F);
        check_hex("off_hex1", bus.HEX1, 7'h7F);
        check_hex("off_hex3", bus.HEX3, 7'h7F);
        check_bcd("off_bcd", bus.bcd, 12'h005);

        // Reset pulse in the middle of a conversion of 37
        bus.ON    = 1'b1;
        bus.value = 8'd37;
        step(4);
        check_bit("mid_busy", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        check_bit("midrst_busy", bus.busy, 1'b0);
        check_hex("midrst_hex0", bus.HEX0, 7'h7F);
        check_bcd("midrst_bcd", bus.bcd, 12'h000);
        step(1);
        rst = 1'b0;
        step(9);
        check_bit("37_busy", bus.busy, 1'b1);
        check_hex("37_not_early", bus.HEX0, 7'h7F);
        step(1);
        check_hex("37_hex0", bus.HEX0, 7'h78);
        check_hex("37_hex1", bus.HEX1, 7'h30);
        check_hex("37_hex2", bus.HEX2, LZ0);
        check_bcd("37_bcd", bus.bcd, 12'h037);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
